// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter in front of one synchronous-read BRAM port.
// Define ARB_ROUND_ROBIN_EN for alternating tie-break; default is fixed priority to req0.
module bram_port_arbiter #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic                  we0,
    input  logic [WIDTH-1:0]      wdata0,
    output logic                  ack0,
    output logic [WIDTH-1:0]      rdata0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic                  we1,
    input  logic [WIDTH-1:0]      wdata1,
    output logic                  ack1,
    output logic [WIDTH-1:0]      rdata1,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic [WIDTH-1:0]      mem_rdata,
    output logic [1:0]            gnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_owner;
    logic                  w_owner_nxt;
    logic                  r_last;
    logic                  w_last_nxt;
    logic                  r_is_wr;
    logic                  w_is_wr_nxt;
    logic                  r_ack0;
    logic                  w_ack0_nxt;
    logic                  r_ack1;
    logic                  w_ack1_nxt;
    logic [WIDTH-1:0]      r_rdata0;
    logic [WIDTH-1:0]      w_rdata0_nxt;
    logic [WIDTH-1:0]      r_rdata1;
    logic [WIDTH-1:0]      w_rdata1_nxt;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [ADDR_WIDTH-1:0] w_mem_addr_nxt;
    logic                  r_mem_we;
    logic                  w_mem_we_nxt;
    logic [WIDTH-1:0]      r_mem_wdata;
    logic [WIDTH-1:0]      w_mem_wdata_nxt;
    logic [1:0]            r_gnt;
    logic [1:0]            w_gnt_nxt;
    logic                  w_win;

`ifdef ARB_ROUND_ROBIN_EN
    assign w_win = (req0 && req1) ? ~r_last : req1;
`else
    // r_last only reaches w_win when req0 is low, where req1 already decides
    assign w_win = req0 ? 1'b0 : (req1 | r_last);
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_last_nxt      = r_last;
        w_is_wr_nxt     = r_is_wr;
        w_ack0_nxt      = r_ack0;
        w_ack1_nxt      = r_ack1;
        w_rdata0_nxt    = r_rdata0;
        w_rdata1_nxt    = r_rdata1;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_we_nxt    = r_mem_we;
        w_mem_wdata_nxt = r_mem_wdata;
        w_gnt_nxt       = r_gnt;
        case (r_state)
            S_IDLE: begin
                w_mem_we_nxt = 1'b0;
                if (req0 || req1) begin
                    w_state_nxt     = S_ISSUE;
                    w_owner_nxt     = w_win;
                    w_is_wr_nxt     = w_win ? we1 : we0;
                    w_mem_addr_nxt  = w_win ? addr1 : addr0;
                    w_mem_we_nxt    = w_win ? we1 : we0;
                    w_mem_wdata_nxt = w_win ? wdata1 : wdata0;
                    w_gnt_nxt       = w_win ? 2'b10 : 2'b01;
                end
            end
            S_ISSUE: begin
                w_state_nxt  = S_CAPTURE;
                w_mem_we_nxt = 1'b0;
            end
            S_CAPTURE: begin
                w_state_nxt = S_DONE;
                if (r_owner) begin
                    w_ack1_nxt = 1'b1;
                    if (!r_is_wr)
                        w_rdata1_nxt = mem_rdata;
                end else begin
                    w_ack0_nxt = 1'b1;
                    if (!r_is_wr)
                        w_rdata0_nxt = mem_rdata;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_ack0_nxt  = 1'b0;
                w_ack1_nxt  = 1'b0;
                w_gnt_nxt   = 2'b00;
                w_last_nxt  = r_owner;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_owner     <= 1'b0;
            r_last      <= 1'b1;
            r_is_wr     <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_gnt       <= 2'b00;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_last      <= w_last_nxt;
            r_is_wr     <= w_is_wr_nxt;
            r_ack0      <= w_ack0_nxt;
            r_ack1      <= w_ack1_nxt;
            r_rdata0    <= w_rdata0_nxt;
            r_rdata1    <= w_rdata1_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_gnt       <= w_gnt_nxt;
        end
    end

    assign ack0      = r_ack0;
    assign ack1      = r_ack1;
    assign rdata0    = r_rdata0;
    assign rdata1    = r_rdata1;
    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;
    assign gnt       = r_gnt;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: vector table of single accesses plus
// tie, busy, mid-access reset and idle sequences against a BRAM model.
module tb_bram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, ack0;
    logic [9:0]  addr0;
    logic [15:0] wdata0, rdata0;
    logic        req1, we1, ack1;
    logic [9:0]  addr1;
    logic [15:0] wdata1, rdata1;
    logic [9:0]  mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [1:0]  gnt;

    int total = 0;
    int bad   = 0;

    bram_port_arbiter #(.WIDTH(16), .ADDR_WIDTH(10)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .we0(we0), .wdata0(wdata0),
        .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .addr1(addr1), .we1(we1), .wdata1(wdata1),
        .ack1(ack1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .gnt(gnt)
    );

    always #10 clk = ~clk;

    bit [15:0] mem [1024];
    bit        loaded = 1'b0;

    always @(posedge clk) begin
        if (!loaded) begin
            mem[5] <= 16'hBEEF;
            loaded <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    int          we_cnt = 0;
    int          ack0_cnt = 0;
    int          ack1_cnt = 0;
    logic [9:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;

    always @(negedge clk) begin
        if (mem_we) begin
            we_cnt  <= we_cnt + 1;
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
        end
        if (ack0) ack0_cnt <= ack0_cnt + 1;
        if (ack1) ack1_cnt <= ack1_cnt + 1;
    end

    typedef struct {
        bit          sel;
        bit          we;
        logic [9:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs [9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic do_access(input vec_t v, input logic [15:0] exp_sel,
                             input logic [15:0] exp_oth);
        int         lat;
        int         wc0;
        bit         seen;
        bit         gok;
        logic [1:0] eg;
        eg  = v.sel ? 2'b10 : 2'b01;
        wc0 = we_cnt;
        if (v.sel) begin
            req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
        end else begin
            req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
        end
        lat  = 0;
        seen = 1'b0;
        gok  = 1'b1;
        while (!seen && lat < 12) begin
            step();
            lat++;
            if (gnt !== eg) gok = 1'b0;
            seen = v.sel ? ack1 : ack0;
        end
        chk("latency", lat, 3);
        chk("gnt_onehot", {31'd0, gok}, 1);
        chk("rdata_win", v.sel ? rdata1 : rdata0, exp_sel);
        chk("rdata_other", v.sel ? rdata0 : rdata1, exp_oth);
        step();
        req0 = 1'b0;
        req1 = 1'b0;
        chk("ack_dropped", {30'd0, ack1, ack0}, 0);
        chk("we_pulses", we_cnt - wc0, v.we ? 1 : 0);
        if (v.we) begin
            chk("wr_addr", wr_addr, v.addr);
            chk("wr_data", wr_data, v.wdata);
        end
    endtask

    initial begin
        logic [15:0] e0;
        logic [15:0] e1;
        logic [15:0] es;
        int          a1s;
        int          t0;
        int          t1;
        int          n;
        bit          ok;
        bit          who;

        vecs[0] = '{1'b0, 1'b0, 10'd5,   16'h0000, 16'hBEEF};
        vecs[1] = '{1'b1, 1'b1, 10'h3F0, 16'h1234, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 10'h3F0, 16'h0000, 16'h1234};
        vecs[3] = '{1'b0, 1'b1, 10'h001, 16'hA5A5, 16'h0000};
        vecs[4] = '{1'b0, 1'b0, 10'h001, 16'h0000, 16'hA5A5};
        vecs[5] = '{1'b1, 1'b0, 10'd5,   16'h0000, 16'hBEEF};
        vecs[6] = '{1'b0, 1'b1, 10'h3FF, 16'hFFFF, 16'h0000};
        vecs[7] = '{1'b0, 1'b0, 10'h3FF, 16'h0000, 16'hFFFF};
        vecs[8] = '{1'b0, 1'b0, 10'h000, 16'h0000, 16'h0000};

        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        reset = 1'b1;
        step();
        step();
        chk("rst_outs", {ack0, ack1, mem_we, gnt, mem_addr},
            17'd0);
        chk("rst_data", {rdata0, rdata1, mem_wdata}, 48'd0);
        reset = 1'b0;
        step();
        chk("post_rst_idle", {29'd0, mem_we, gnt}, 0);

        e0 = 16'h0;
        e1 = 16'h0;
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].we) es = vecs[i].sel ? e1 : e0;
            else            es = vecs[i].exp_rd;
            if (vecs[i].sel) begin
                do_access(vecs[i], es, e0);
                e1 = es;
            end else begin
                do_access(vecs[i], es, e1);
                e0 = es;
            end
        end

        // tie: both held continuously across four accesses
        do_reset();
        a1s = ack1_cnt;
        req0 = 1'b1; we0 = 1'b0; addr0 = 10'd5;
        req1 = 1'b1; we1 = 1'b0; addr1 = 10'h3F0;
        for (int k = 0; k < 4; k++) begin
            n   = 0;
            who = 1'b0;
            while (!(ack0 || ack1) && n < 10) begin
                step();
                n++;
            end
            chk("tie_ack_seen", {31'd0, ack0 | ack1}, 1);
            who = ack1;
            if (k == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
`ifdef ARB_ROUND_ROBIN_EN
            chk("tie_order", {31'd0, who}, k % 2);
`else
            chk("tie_order", {31'd0, who}, 0);
`endif
            step();
        end
        step();
`ifdef ARB_ROUND_ROBIN_EN
        chk("tie_ack1_count", ack1_cnt - a1s, 2);
`else
        chk("tie_ack1_count", ack1_cnt - a1s, 0);
`endif

        // req1 arrives during CAPTURE of a req0 read
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 10'd5;
        we1 = 1'b0; addr1 = 10'h3F0;
        t0 = 0;
        t1 = 0;
        for (int i = 1; i <= 14; i++) begin
            step();
            if (t0 != 0 && req0) req0 = 1'b0;
            if (t1 != 0 && req1) req1 = 1'b0;
            if (i == 2) req1 = 1'b1;
            if (ack0 && t0 == 0) t0 = i;
            if (ack1 && t1 == 0) t1 = i;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        chk("busy_ack0_time", t0, 3);
        chk("busy_ack_gap", t1 - t0, 4);
        chk("busy_rdata1", rdata1, 16'h1234);
        chk("busy_rdata0", rdata0, 16'hBEEF);

        // reset asserted in CAPTURE
        a1s = ack0_cnt;
        req0 = 1'b1; we0 = 1'b0; addr0 = 10'h3F0;
        step();
        step();
        chk("mid_gnt_pre", {30'd0, gnt}, 2'b01);
        reset = 1'b1;
        step();
        req0 = 1'b0;
        chk("mid_rst_outs", {ack0, ack1, mem_we, gnt}, 5'd0);
        chk("mid_rst_rdata0", rdata0, 16'h0000);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("mid_no_ack", ack0_cnt - a1s, 0);
        do_access(vecs[2] , 16'h1234, 16'h0000);

        // idle hold
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (mem_we || gnt != 2'b00 || ack0 || ack1) ok = 1'b0;
        end
        chk("idle_hold", {31'd0, ok}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
